fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, value driven on Instr after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port stall, input, 1, downstream not accepting the presented instruction.
REQ-006 SHALL have port PCsrc, input, 1, branch taken for the presented instruction (from control).
REQ-007 SHALL have port ImmOp, input, 32, sign-extended branch offset for the presented instruction.
REQ-008 SHALL have port imem_req, output, 1, instruction-memory request valid.
REQ-009 SHALL have port imem_addr, output, 32, byte address of the request.
REQ-010 SHALL have port imem_ack, input, 1, memory returns imem_rdata this cycle; may assert in the same cycle as imem_req.
REQ-011 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-012 SHALL have port Instr, output, 32, presented instruction (to control/decode).
REQ-013 SHALL have port instr_valid, output, 1, Instr/PC hold a valid instruction.
REQ-014 SHALL have port PC, output, 32, address of the presented instruction.

Function
REQ-015 SHALL consume the presented instruction when instr_valid=1 and stall=0 in the same cycle ("consume"); PCsrc/ImmOp SHALL be ignored in all other cycles.
REQ-016 SHALL compute next fetch address on consume as PCsrc ? PC+ImmOp : PC+4, 32-bit modulo arithmetic, no overflow detection.
REQ-017 SHALL keep imem_req and imem_addr stable from assertion until the cycle imem_ack=1; no request is withdrawn or re-addressed.
REQ-018 SHALL implement states IDLE, FETCH, VALID, DROP.
REQ-019 IDLE: entered at reset; to FETCH on first clock after rst deasserts.
REQ-020 FETCH: imem_req=1 at fetch address; on imem_ack, register imem_rdata into Instr, address into PC, go to VALID.
REQ-021 VALID: instr_valid=1; Instr and PC held while stall=1; on consume go to FETCH at next address.
REQ-022 DROP: entered when a consume with PCsrc=1 occurs while a prefetch request is unacknowledged; keep requesting old address, discard data on imem_ack, then FETCH the branch target.
REQ-023 SHALL hold instr_valid=0 in IDLE, FETCH and DROP; Instr and PC keep their last values while invalid.
REQ-024 Without prefetch, latency SHALL be: ack in cycle N -> instr_valid=1 in cycle N+1; peak throughput one instruction per two cycles.

Reset
REQ-025 SHALL on rst=0, immediately and regardless of clock: state=IDLE, PC=RESET_PC, Instr=NOP_INSTR, instr_valid=0, imem_req=0, imem_addr=RESET_PC, prefetch buffer empty.
REQ-026 Reset mid-request SHALL abandon the request; any later imem_ack for it SHALL be ignored.

Configuration
REQ-027 Macro FETCH_PREFETCH_EN defined: in VALID, SHALL request PC+4 concurrently; ack with same-cycle consume and PCsrc=0 -> data goes straight to Instr, instr_valid stays 1 (one instruction per cycle); ack without consume -> stored in a one-entry buffer, further requests stop; consume with buffer full and PCsrc=0 -> Instr from buffer; consume with PCsrc=1 -> buffer cleared, DROP if request outstanding, else FETCH target.
REQ-028 Macro FETCH_PREFETCH_EN undefined: no requests issued in VALID, no buffer, DROP unreachable.

Structure
REQ-029 Package fetch_pkg SHALL hold the state enum, INSTR_BYTES=4 and the default NOP constant.
REQ-030 Sub-module pc_next SHALL implement the PC+4 / PC+ImmOp adder and select.

Verification
REQ-031 rst=0 then released, imem_ack tied 1, rdata=32'h00500093 -> imem_addr=0 in first cycle, instr_valid=1 next cycle with Instr=32'h00500093, PC=0.
REQ-032 Consume at PC=0x10 with PCsrc=1, ImmOp=32'hFFFF_FFF8 -> next imem_addr=0x08.
REQ-033 stall=1 for 5 cycles at PC=0x04 -> Instr, PC unchanged, no consume; stall=0 -> next address 0x08.
REQ-034 imem_ack delayed 3 cycles -> imem_req/imem_addr stable throughout, instr_valid=0 until capture.
REQ-035 With FETCH_PREFETCH_EN, ack tied 1, stall=0 -> PC sequence 0,4,8,0xC on consecutive cycles.
REQ-036 With FETCH_PREFETCH_EN, prefetch of 0x14 pending, consume at 0x10 with PCsrc=1, ImmOp=0x40 -> 0x14 data discarded, next valid PC=0x50.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_VALID = 2'd2,
      S_DROP  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] INSTR_BYTES = 32'd4;
   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface fetch_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/pc_next.sv
// Next-PC adder: sequential PC+4 or branch target PC+ImmOp, 32-bit wraparound.
module pc_next
   import fetch_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        branch_i,
   input  logic [31:0] imm_i,
   output logic [31:0] next_o
);

   assign next_o = branch_i ? (pc_i + imm_i) : (pc_i + INSTR_BYTES);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/VALID/DROP FSM feeding decode.
// Define FETCH_PREFETCH_EN to prefetch PC+4 in VALID through a one-entry buffer.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        PCsrc,
   input  logic [31:0] ImmOp,
   fetch_if.master     imem,
   output logic [31:0] Instr,
   output logic        instr_valid,
   output logic [31:0] PC
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  pc_tgt;
   logic         consume;
`ifdef FETCH_PREFETCH_EN
   logic [31:0]  buf_q, buf_d;
   logic         buf_vld_q, buf_vld_d;
   logic [31:0]  tgt_q, tgt_d;
   logic         pf_ack;
`endif

   assign consume = (state_q == S_VALID) && !stall;

   pc_next u_pc_next (
      .pc_i     (pc_q),
      .branch_i (PCsrc),
      .imm_i    (ImmOp),
      .next_o   (pc_tgt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= NOP_INSTR;
         addr_q    <= RESET_PC;
`ifdef FETCH_PREFETCH_EN
         buf_vld_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         addr_q    <= addr_d;
`ifdef FETCH_PREFETCH_EN
         buf_vld_q <= buf_vld_d;
`endif
      end
   end

`ifdef FETCH_PREFETCH_EN
   // Buffer word and pending branch target are qualified by buf_vld_q / state, so no reset.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
      tgt_q <= tgt_d;
   end

   assign pf_ack = !buf_vld_q && imem.imem_ack;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      addr_d    = addr_q;
`ifdef FETCH_PREFETCH_EN
      buf_d     = buf_q;
      buf_vld_d = buf_vld_q;
      tgt_d     = tgt_q;
`endif
      unique case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (imem.imem_ack) begin
               state_d = S_VALID;
               instr_d = imem.imem_rdata;
               pc_d    = addr_q;
`ifdef FETCH_PREFETCH_EN
               addr_d  = addr_q + INSTR_BYTES;
`endif
            end
         end
         S_VALID: begin
`ifdef FETCH_PREFETCH_EN
            // addr_q holds PC+4 here: it is the prefetch address while in VALID.
            if (consume && PCsrc) begin
               buf_vld_d = 1'b0;
               if (pf_ack || buf_vld_q) begin
                  state_d = S_FETCH;
                  addr_d  = pc_tgt;
               end else begin
                  state_d = S_DROP;
                  tgt_d   = pc_tgt;
               end
            end else if (consume) begin
               if (buf_vld_q) begin
                  instr_d   = buf_q;
                  pc_d      = pc_tgt;
                  buf_vld_d = 1'b0;
                  addr_d    = pc_tgt + INSTR_BYTES;
               end else if (pf_ack) begin
                  instr_d = imem.imem_rdata;
                  pc_d    = addr_q;
                  addr_d  = addr_q + INSTR_BYTES;
               end else begin
                  state_d = S_FETCH;
               end
            end else if (pf_ack) begin
               buf_d     = imem.imem_rdata;
               buf_vld_d = 1'b1;
            end
`else
            if (consume) begin
               state_d = S_FETCH;
               addr_d  = pc_tgt;
            end
`endif
         end
`ifdef FETCH_PREFETCH_EN
         S_DROP: begin
            if (imem.imem_ack) begin
               state_d = S_FETCH;
               addr_d  = tgt_q;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem.imem_req = 1'b0;
      instr_valid   = (state_q == S_VALID);
      unique case (state_q)
         S_FETCH: imem.imem_req = 1'b1;
`ifdef FETCH_PREFETCH_EN
         S_DROP:  imem.imem_req = 1'b1;
         S_VALID: imem.imem_req = !buf_vld_q;
`endif
         default: imem.imem_req = 1'b0;
      endcase
   end

   assign imem.imem_addr = addr_q;
   assign Instr          = instr_q;
   assign PC             = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit; memory contents derive from the address.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        PCsrc;
   logic [31:0] ImmOp;
   logic [31:0] Instr;
   logic        instr_valid;
   logic [31:0] PC;
   logic        use_fixed;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_if imem ();

   fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .PCsrc       (PCsrc),
      .ImmOp       (ImmOp),
      .imem        (imem),
      .Instr       (Instr),
      .instr_valid (instr_valid),
      .PC          (PC)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   always_comb imem.imem_rdata = use_fixed ? 32'h0050_0093 : mem_word(imem.imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      check(tag, {31'd0, obs}, {31'd0, exp});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      step();
      while (!instr_valid && k < 20) begin
         step();
         k++;
      end
      check1({tag, "_timeout"}, instr_valid, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      logic        prev_req, prev_ack, prev_hold;
      logic [31:0] prev_addr, prev_pc, prev_instr;
      int          idle_cnt, consumed;

      rst = 1'b0; stall = 1'b0; PCsrc = 1'b0; ImmOp = '0;
      imem.imem_ack = 1'b0; use_fixed = 1'b1;

      // Reset state
      #12;
      check1("rst_req", imem.imem_req, 1'b0);
      check("rst_addr", imem.imem_addr, 32'h0);
      check1("rst_valid", instr_valid, 1'b0);
      check("rst_pc", PC, 32'h0);
      check("rst_instr", Instr, 32'h0000_0013);

      // Ack tied high, fixed read data: first fetch then first valid instruction
      step();
      rst = 1'b1;
      imem.imem_ack = 1'b1;
      step();
      check1("first_req", imem.imem_req, 1'b1);
      check("first_addr", imem.imem_addr, 32'h0);
      check1("first_valid_low", instr_valid, 1'b0);
      step();
      check1("first_valid", instr_valid, 1'b1);
      check("first_instr", Instr, 32'h0050_0093);
      check("first_pc", PC, 32'h0);
      use_fixed = 1'b0;

`ifndef FETCH_PREFETCH_EN
      wait_valid("pc4");
      stall = 1'b1;
      check("pc4_pc", PC, 32'h4);
      check("pc4_instr", Instr, mem_word(32'h4));
      for (int i = 0; i < 5; i++) begin
         step();
         check1("stall_valid", instr_valid, 1'b1);
         check("stall_pc", PC, 32'h4);
         check("stall_instr", Instr, mem_word(32'h4));
         check1("stall_req", imem.imem_req, 1'b0);
      end
      stall = 1'b0;
      imem.imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check1("late_req", imem.imem_req, 1'b1);
         check("late_addr", imem.imem_addr, 32'h8);
         check1("late_valid", instr_valid, 1'b0);
      end
      imem.imem_ack = 1'b1;
      step();
      check1("late_cap_valid", instr_valid, 1'b1);
      check("late_cap_pc", PC, 32'h8);
      check("late_cap_instr", Instr, mem_word(32'h8));
      wait_valid("pcC");
      check("pcC_pc", PC, 32'hC);
      wait_valid("pc10");
      check("pc10_pc", PC, 32'h10);
      PCsrc = 1'b1;
      ImmOp = 32'hFFFF_FFF8;
      step();
      PCsrc = 1'b0;
      ImmOp = '0;
      check1("br_req", imem.imem_req, 1'b1);
      check("br_addr", imem.imem_addr, 32'h8);
      wait_valid("br_tgt");
      check("br_tgt_pc", PC, 32'h8);
      check("br_tgt_instr", Instr, mem_word(32'h8));
`else
      for (int i = 1; i <= 4; i++) begin
         step();
         check1("pf_seq_valid", instr_valid, 1'b1);
         check("pf_seq_pc", PC, 32'(i * 4));
         check("pf_seq_instr", Instr, mem_word(32'(i * 4)));
      end
      imem.imem_ack = 1'b0;
      PCsrc = 1'b1;
      ImmOp = 32'h40;
      step();
      PCsrc = 1'b0;
      ImmOp = '0;
      check1("drop_valid", instr_valid, 1'b0);
      check1("drop_req", imem.imem_req, 1'b1);
      check("drop_addr", imem.imem_addr, 32'h14);
      imem.imem_ack = 1'b1;
      step();
      check1("drop_done_valid", instr_valid, 1'b0);
      check1("drop_done_req", imem.imem_req, 1'b1);
      check("drop_done_addr", imem.imem_addr, 32'h50);
      step();
      check1("tgt_valid", instr_valid, 1'b1);
      check("tgt_pc", PC, 32'h50);
      check("tgt_instr", Instr, mem_word(32'h50));
`endif

      // Asynchronous reset mid-cycle, stray acks during reset
      stall = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check1("arst_req", imem.imem_req, 1'b0);
      check("arst_addr", imem.imem_addr, 32'h0);
      check1("arst_valid", instr_valid, 1'b0);
      check("arst_pc", PC, 32'h0);
      check("arst_instr", Instr, 32'h0000_0013);
      step();
      imem.imem_ack = 1'b1;
      step();
      imem.imem_ack = 1'b0;
      stall = 1'b0;
      rst = 1'b1;

      // Randomized traffic against a stream-level model of the expected PC sequence
      exp_pc = 32'h0;
      prev_req = 1'b0; prev_ack = 1'b0; prev_hold = 1'b0;
      prev_addr = '0; prev_pc = '0; prev_instr = '0;
      idle_cnt = 0; consumed = 0;
      for (int i = 0; i < 800; i++) begin
         step();
         if (prev_req && !prev_ack) begin
            check1("rnd_req_hold", imem.imem_req, 1'b1);
            check("rnd_addr_hold", imem.imem_addr, prev_addr);
         end
         if (prev_hold) begin
            check1("rnd_stall_valid", instr_valid, 1'b1);
            check("rnd_stall_pc", PC, prev_pc);
            check("rnd_stall_instr", Instr, prev_instr);
         end
         if (instr_valid) begin
            check("rnd_pc", PC, exp_pc);
            check("rnd_instr", Instr, mem_word(exp_pc));
            idle_cnt = 0;
         end else begin
            idle_cnt++;
         end
         if (idle_cnt > 40) begin
            check("rnd_progress_timeout", 32'(idle_cnt), 32'd0);
            break;
         end
         stall = ($urandom % 4) == 0;
         PCsrc = ($urandom % 4) == 0;
         ImmOp = 32'(($urandom_range(0, 31) * 4)) - 32'd64;
         imem.imem_ack = imem.imem_req && (($urandom % 3) != 0);
         if (instr_valid && !stall) begin
            consumed++;
            exp_pc = PCsrc ? (exp_pc + ImmOp) : (exp_pc + 32'd4);
         end
         prev_req   = imem.imem_req;
         prev_ack   = imem.imem_ack;
         prev_addr  = imem.imem_addr;
         prev_hold  = instr_valid && stall;
         prev_pc    = PC;
         prev_instr = Instr;
      end
      check1("rnd_consumed", consumed > 50, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
